// File: rtl/wb_stage_pipelined_if.sv
// wb_stage_pipelined_if
//   MEM -> WB bundle for the write-back stage. Carries the pipeline controls
//   (stall/flush), the MEM-stage results captured by the stage, and the
//   registered register-file write port / forwarding outputs it produces.
//   Parameters:
//     NB_DATA : datapath width (32 or 64)
//     NB_REG  : register index width
//   Modports:
//     master : MEM-stage side, drives i_* and observes o_*
//     slave  : write-back stage, reads i_* and drives o_*
interface wb_stage_pipelined_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
);
    localparam int NB_OFF = $clog2(NB_DATA / 8);

    logic                i_stall;
    logic                i_flush;
    logic                i_valid;
    logic                i_reg_write;
    logic [1:0]          i_wb_sel;
    logic [1:0]          i_mem_size;
    logic                i_mem_unsigned;
    logic [NB_OFF-1:0]   i_byte_offset;
    logic [NB_DATA-1:0]  i_mem_data;
    logic [NB_DATA-1:0]  i_alu_result;
    logic [NB_DATA-1:0]  i_link_pc;
    logic [NB_REG-1:0]   i_dest_reg;

    logic                o_valid;
    logic                o_reg_write;
    logic [NB_DATA-1:0]  o_wb_data;
    logic [NB_REG-1:0]   o_wb_reg;

    modport master (
        output i_stall, i_flush, i_valid, i_reg_write, i_wb_sel, i_mem_size,
               i_mem_unsigned, i_byte_offset, i_mem_data, i_alu_result,
               i_link_pc, i_dest_reg,
        input  o_valid, o_reg_write, o_wb_data, o_wb_reg
    );

    modport slave (
        input  i_stall, i_flush, i_valid, i_reg_write, i_wb_sel, i_mem_size,
               i_mem_unsigned, i_byte_offset, i_mem_data, i_alu_result,
               i_link_pc, i_dest_reg,
        output o_valid, o_reg_write, o_wb_data, o_wb_reg
    );
endinterface

// File: rtl/wb_stage_pipelined.sv
// wb_stage_pipelined
//   Write-back stage with its own MEM/WB register. Selects the write-back
//   source (ALU / extracted load / link address), performs little-endian
//   byte/half/word/full load extraction with sign or zero extension, and
//   registers the result. All outputs come straight from flops (1 cycle).
//   Edge priority: reset > flush > stall > load. Writes to register 0 are
//   suppressed at capture.
//   Ports:
//     i_clock          : clock, rising edge
//     i_reset          : asynchronous reset, active-high
//     bus (slave)      : stall/flush controls, MEM-stage inputs, WB outputs
//     o_retired_count  : retired instruction count (only with the macro)
//   Optional feature: define WB_RETIRE_CNT_EN to add o_retired_count, a
//   wrapping 32-bit count of valid instructions captured (not flushed or
//   stalled).
module wb_stage_pipelined #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic                i_clock,
    input  logic                i_reset,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]         o_retired_count,
`endif
    wb_stage_pipelined_if.slave bus
);
    localparam int NB_OFF = $clog2(NB_DATA / 8);

    logic [NB_OFF-1:0]  half_off;
    logic [NB_OFF-1:0]  word_off;
    logic [NB_DATA-1:0] shifted;
    logic [NB_DATA-1:0] mask;
    logic               load_msb;
    logic [NB_DATA-1:0] load_data;
    logic [NB_DATA-1:0] sel_data;
    logic               capture_we;

    logic               valid_q;
    logic               reg_write_q;
    logic [NB_DATA-1:0] wb_data_q;
    logic [NB_REG-1:0]  wb_reg_q;

    // Shift the addressed lane down to bit 0, then mask to the load size and
    // fill the upper bits. Misaligned offsets are truncated by clearing the
    // low offset bits rather than slicing, so the same code works for
    // NB_OFF=2 and NB_OFF=3. Full-width (and 32-bit word on a 32-bit path)
    // loads end up with mask all ones, so no fill is applied.
    always_comb begin
        half_off = bus.i_byte_offset & ~NB_OFF'(1);
        word_off = bus.i_byte_offset & ~NB_OFF'(3);
        shifted  = bus.i_mem_data;
        mask     = '1;
        load_msb = 1'b0;
        case (bus.i_mem_size)
            2'b00: begin
                shifted  = bus.i_mem_data >> {bus.i_byte_offset, 3'b000};
                mask     = NB_DATA'(8'hFF);
                load_msb = shifted[7];
            end
            2'b01: begin
                shifted  = bus.i_mem_data >> {half_off, 3'b000};
                mask     = NB_DATA'(16'hFFFF);
                load_msb = shifted[15];
            end
            2'b10: begin
                shifted  = bus.i_mem_data >> {word_off, 3'b000};
                mask     = NB_DATA'(32'hFFFF_FFFF);
                load_msb = shifted[31];
            end
            default: begin
                shifted  = bus.i_mem_data;
                mask     = '1;
                load_msb = 1'b0;
            end
        endcase
        load_data = (shifted & mask) |
                    ((!bus.i_mem_unsigned && load_msb) ? ~mask : '0);
    end

    always_comb begin
        sel_data = bus.i_alu_result;
        case (bus.i_wb_sel)
            2'b01:   sel_data = load_data;
            2'b10:   sel_data = bus.i_link_pc;
            default: sel_data = bus.i_alu_result;
        endcase
    end

    assign capture_we = bus.i_valid & bus.i_reg_write & (bus.i_dest_reg != '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            wb_data_q   <= '0;
            wb_reg_q    <= '0;
        end else if (bus.i_flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (!bus.i_stall) begin
            valid_q     <= bus.i_valid;
            reg_write_q <= capture_we;
            wb_data_q   <= sel_data;
            wb_reg_q    <= bus.i_dest_reg;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_reg_write = reg_write_q;
    assign bus.o_wb_data   = wb_data_q;
    assign bus.o_wb_reg    = wb_reg_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_count_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            retired_count_q <= '0;
        end else if (bus.i_valid && !bus.i_flush && !bus.i_stall) begin
            retired_count_q <= retired_count_q + 32'd1;
        end
    end

    assign o_retired_count = retired_count_q;
`endif
endmodule

// File: tb/tb_wb_stage_pipelined.sv
// tb_wb_stage_pipelined
//   Directed bench for wb_stage_pipelined (NB_DATA=32, NB_REG=5). Inputs are
//   driven 1 ns after a rising edge; outputs are checked 1 ns after the edge
//   that captures them. Counter checks are compiled only with
//   WB_RETIRE_CNT_EN defined.
module tb_wb_stage_pipelined;
    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;

    logic i_clock;
    logic i_reset;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] o_retired_count;
`endif

    int vectors;
    int miscompares;

    wb_stage_pipelined_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) bus ();

    wb_stage_pipelined #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
`ifdef WB_RETIRE_CNT_EN
        .o_retired_count (o_retired_count),
`endif
        .bus             (bus)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic rw,
                           input logic [31:0] d, input logic [4:0] r);
        chk({tag, ".valid"},     64'(bus.o_valid),     64'(v));
        chk({tag, ".reg_write"}, 64'(bus.o_reg_write), 64'(rw));
        chk({tag, ".wb_data"},   64'(bus.o_wb_data),   64'(d));
        chk({tag, ".wb_reg"},    64'(bus.o_wb_reg),    64'(r));
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] link, input logic [4:0] dest);
        bus.i_valid        = v;
        bus.i_reg_write    = rw;
        bus.i_wb_sel       = sel;
        bus.i_mem_size     = size;
        bus.i_mem_unsigned = uns;
        bus.i_byte_offset  = off;
        bus.i_mem_data     = mem;
        bus.i_alu_result   = alu;
        bus.i_link_pc      = link;
        bus.i_dest_reg     = dest;
    endtask

    localparam logic [31:0] MEM = 32'h80FF_7F01;

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_reset     = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive(0, 0, 2'b00, 2'b00, 0, 2'd0, '0, '0, '0, 5'd0);
        #12;
        i_reset = 1'b0;
        #1;
        chk_out("reset", 0, 0, 32'h0, 5'd0);
        tick();
        chk_out("idle", 0, 0, 32'h0, 5'd0);

        // ALU path
        drive(1, 1, 2'b00, 2'b00, 0, 2'd3, MEM, 32'h1234_5678, 32'h0, 5'd5);
        tick();
        chk_out("alu", 1, 1, 32'h1234_5678, 5'd5);

        // Reserved select behaves as ALU
        drive(1, 1, 2'b11, 2'b00, 0, 2'd3, MEM, 32'hCAFE_0001, 32'h0, 5'd6);
        tick();
        chk_out("sel11", 1, 1, 32'hCAFE_0001, 5'd6);

        // Loads
        drive(1, 1, 2'b01, 2'b00, 0, 2'd3, MEM, 32'h0, 32'h0, 5'd8);
        tick();
        chk("lb_off3_s", 64'(bus.o_wb_data), 64'h0000_0000_FFFF_FF80);
        drive(1, 1, 2'b01, 2'b00, 1, 2'd3, MEM, 32'h0, 32'h0, 5'd8);
        tick();
        chk("lb_off3_u", 64'(bus.o_wb_data), 64'h0000_0080);
        drive(1, 1, 2'b01, 2'b00, 0, 2'd1, MEM, 32'h0, 32'h0, 5'd8);
        tick();
        chk("lb_off1_s", 64'(bus.o_wb_data), 64'h0000_007F);
        drive(1, 1, 2'b01, 2'b00, 0, 2'd2, MEM, 32'h0, 32'h0, 5'd8);
        tick();
        chk("lb_off2_s", 64'(bus.o_wb_data), 64'hFFFF_FFFF);
        drive(1, 1, 2'b01, 2'b01, 0, 2'd2, MEM, 32'h0, 32'h0, 5'd9);
        tick();
        chk_out("lh_off2_s", 1, 1, 32'hFFFF_80FF, 5'd9);
        drive(1, 1, 2'b01, 2'b01, 0, 2'd3, MEM, 32'h0, 32'h0, 5'd9);
        tick();
        chk("lh_off3_s", 64'(bus.o_wb_data), 64'hFFFF_80FF);
        drive(1, 1, 2'b01, 2'b01, 1, 2'd2, MEM, 32'h0, 32'h0, 5'd9);
        tick();
        chk("lh_off2_u", 64'(bus.o_wb_data), 64'h0000_80FF);
        drive(1, 1, 2'b01, 2'b01, 0, 2'd1, MEM, 32'h0, 32'h0, 5'd9);
        tick();
        chk("lh_off1_s", 64'(bus.o_wb_data), 64'h0000_7F01);
        drive(1, 1, 2'b01, 2'b10, 0, 2'd3, MEM, 32'h0, 32'h0, 5'd10);
        tick();
        chk("lw", 64'(bus.o_wb_data), 64'h80FF_7F01);
        drive(1, 1, 2'b01, 2'b11, 1, 2'd1, MEM, 32'h0, 32'h0, 5'd10);
        tick();
        chk("lfull", 64'(bus.o_wb_data), 64'h80FF_7F01);

        // Link and register 0
        drive(1, 1, 2'b10, 2'b00, 0, 2'd0, MEM, 32'h0, 32'h0040_0008, 5'd31);
        tick();
        chk_out("link31", 1, 1, 32'h0040_0008, 5'd31);
        drive(1, 1, 2'b10, 2'b00, 0, 2'd0, MEM, 32'h0, 32'h0040_0008, 5'd0);
        tick();
        chk("link0.valid", 64'(bus.o_valid), 64'd1);
        chk("link0.reg_write", 64'(bus.o_reg_write), 64'd0);

        // Invalid capture
        drive(0, 1, 2'b00, 2'b00, 0, 2'd0, MEM, 32'h5, 32'h0, 5'd4);
        tick();
        chk("invalid.valid", 64'(bus.o_valid), 64'd0);
        chk("invalid.reg_write", 64'(bus.o_reg_write), 64'd0);

        // Valid without reg_write
        drive(1, 0, 2'b00, 2'b00, 0, 2'd0, MEM, 32'h77, 32'h0, 5'd4);
        tick();
        chk_out("nowrite", 1, 0, 32'h77, 5'd4);

        // Stall holds A for 3 cycles, then stall+flush squashes
        drive(1, 1, 2'b00, 2'b00, 0, 2'd0, MEM, 32'hAAAA_5555, 32'h0, 5'd7);
        tick();
        chk_out("stallA", 1, 1, 32'hAAAA_5555, 5'd7);
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'b10, 2'b00, 0, 2'd0, MEM, 32'h1111_0000 + 32'(i),
                  32'h2222_0000, 5'd9 + 5'(i));
            tick();
            chk_out("stall_hold", 1, 1, 32'hAAAA_5555, 5'd7);
        end
        drive(0, 0, 2'b00, 2'b00, 0, 2'd0, MEM, 32'h3333_3333, 32'h0, 5'd12);
        tick();
        chk_out("stall_invalid_hold", 1, 1, 32'hAAAA_5555, 5'd7);
        bus.i_flush = 1'b1;
        drive(1, 1, 2'b00, 2'b00, 0, 2'd0, MEM, 32'h4444_4444, 32'h0, 5'd13);
        tick();
        chk("stallflush.valid", 64'(bus.o_valid), 64'd0);
        chk("stallflush.reg_write", 64'(bus.o_reg_write), 64'd0);
        bus.i_stall = 1'b0;
        tick();
        chk("flush.valid", 64'(bus.o_valid), 64'd0);
        chk("flush.reg_write", 64'(bus.o_reg_write), 64'd0);
        bus.i_flush = 1'b0;
        tick();
        chk_out("after_flush", 1, 1, 32'h4444_4444, 5'd13);

        // Asynchronous reset mid-stream
        drive(1, 1, 2'b00, 2'b00, 0, 2'd0, MEM, 32'hDEAD_BEEF, 32'h0, 5'd3);
        tick();
        chk_out("pre_areset", 1, 1, 32'hDEAD_BEEF, 5'd3);
        #2;
        i_reset = 1'b1;
        #1;
        chk_out("areset", 0, 0, 32'h0, 5'd0);
        tick();
        chk_out("areset_held", 0, 0, 32'h0, 5'd0);
        #1;
        i_reset = 1'b0;
        tick();
        chk_out("after_areset", 1, 1, 32'hDEAD_BEEF, 5'd3);

`ifdef WB_RETIRE_CNT_EN
        #1;
        i_reset = 1'b1;
        #1;
        chk("cnt_reset", 64'(o_retired_count), 64'd0);
        i_reset = 1'b0;
        // 10 valid cycles: cycles 2 and 5 stalled, cycle 8 flushed
        for (int i = 0; i < 10; i++) begin
            drive(1, i[0], 2'b00, 2'b00, 0, 2'd0, MEM, 32'(i), 32'h0, 5'd1);
            bus.i_stall = (i == 2 || i == 5);
            bus.i_flush = (i == 8);
            tick();
        end
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive(0, 0, 2'b00, 2'b00, 0, 2'd0, MEM, 32'h0, 32'h0, 5'd0);
        tick();
        chk("cnt_seven", 64'(o_retired_count), 64'd7);
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        #1;
        chk("cnt_preload", 64'(o_retired_count), 64'hFFFF_FFFF);
        drive(1, 1, 2'b00, 2'b00, 0, 2'd0, MEM, 32'h0, 32'h0, 5'd2);
        tick();
        chk("cnt_wrap", 64'(o_retired_count), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_stage_pipelined.md
Name: wb_stage_pipelined

Overview:
Parametrised write-back stage with its own MEM/WB pipeline register. It captures MEM-stage results on the clock edge and selects the write-back source: ALU result, load data or link address. It performs byte/halfword/word load extraction with sign or zero extension, and drives the register-file write port. It sits between the MEM stage and the register file. It also feeds the forwarding unit from its registered outputs.

Parameters:
NB_DATA, 32, datapath width in bits; must be a multiple of 32 (32 or 64 supported).
NB_REG, 5, register index width.
NB_OFF, $clog2(NB_DATA/8), byte-offset width; localparam, not overridable.

Ports:
i_clock  in  1  system clock, rising edge.
i_reset  in  1  asynchronous reset, active-high.
i_stall  in  1  hold pipeline register contents.
i_flush  in  1  squash the instruction being captured.
i_valid  in  1  MEM-stage instruction valid.
i_reg_write  in  1  instruction writes the register file.
i_wb_sel  in  2  source select: 00 ALU, 01 memory, 10 link, 11 reserved (ALU).
i_mem_size  in  2  load size: 00 byte, 01 half, 10 word (32b), 11 full NB_DATA.
i_mem_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
i_byte_offset  in  NB_OFF  load address low bits.
i_mem_data  in  NB_DATA  raw memory read word.
i_alu_result  in  NB_DATA  ALU result.
i_link_pc  in  NB_DATA  return address (PC+8).
i_dest_reg  in  NB_REG  destination register.
o_valid  out  1  registered valid.
o_reg_write  out  1  register-file write enable.
o_wb_data  out  NB_DATA  write-back data.
o_wb_reg  out  NB_REG  write-back register index.

Behaviour:
- Reset (async, i_reset=1): o_valid=0, o_reg_write=0, o_wb_data=0, o_wb_reg=0 immediately. A reset asserted mid-operation discards any held instruction.
- Latency: 1 cycle. Values present at rising edge N appear on the outputs after edge N. All outputs come straight from flops, with no combinational input-to-output path.
- Source selection and extraction are combinational before the register.
- Lanes are little-endian: byte k = i_mem_data[8k+7:8k].
  - Byte: lane i_byte_offset.
  - Half: lanes selected by i_byte_offset with bit 0 ignored.
  - Word: 32-bit lane selected by i_byte_offset with the low 2 bits ignored.
  - Full: unaltered.
  - Misaligned offsets are truncated silently; no exception is raised.
- Extension fills bits above the loaded size up to NB_DATA: copies of the loaded MSB when i_mem_unsigned=0, zeros when i_mem_unsigned=1. Word loads with NB_DATA=32 are unaltered.
- Extraction applies only when i_wb_sel=01; otherwise i_mem_size, i_mem_unsigned and i_byte_offset are ignored.
- Captured write enable = i_valid & i_reg_write & (i_dest_reg != 0). Writes to register 0 are never issued.
- Priority on the clock edge: reset > flush > stall > load.
  - Flush: o_valid=0 and o_reg_write=0 next cycle; data/reg outputs may hold any value.
  - Stall (no flush): all registers hold.
  - Flush and stall together: flush wins.
- When i_valid=0 and there is no stall, the capture clears o_valid and o_reg_write; data is don't-care.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: adds output port o_retired_count (out, 32 bits).
  - Reset value 0.
  - Increments by 1 on each edge where a valid, non-flushed, non-stalled instruction is captured, whether or not it writes a register.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then release, no stimulus -> all outputs 0; assert i_reset mid-stream with o_reg_write=1 -> o_reg_write=0 same cycle without a clock edge.
- ALU path: sel=00, alu=0x12345678, dest=5, reg_write=1, valid=1 -> next cycle o_wb_data=0x12345678, o_wb_reg=5, o_reg_write=1.
- Byte loads: mem=0x80FF7F01.
  - offset 3, signed -> 0xFFFFFF80.
  - offset 3, unsigned -> 0x00000080.
  - offset 1, signed -> 0x0000007F.
  - Half, offset 2, signed -> 0xFFFF80FF.
  - Half, offset 3 -> same as offset 2.
- Link and $0: sel=10, link_pc=0x00400008, dest=31 -> o_wb_data=0x00400008, o_reg_write=1; same with dest=0 -> o_reg_write=0, o_valid=1.
- Stall/flush: capture A; assert stall for 3 cycles with new inputs -> outputs stay A; assert stall+flush -> o_valid=0, o_reg_write=0.
- WB_RETIRE_CNT_EN: 10 valid captures, with 2 of them stalled and 1 flushed -> o_retired_count=7; preload the counter near wrap (force) -> 0xFFFFFFFF + 1 = 0.
